// File: rtl/pe_row_sched.sv
// Row scheduler for the 8-pixel, 3-tap, 2-bit convolution PE: feeds one row at a
// time, waits out the PE latency, and presents each result with its row index.
module pe_row_sched #(
  parameter int unsigned ROWS   = 8,
  parameter int unsigned PE_LAT = 1,
  localparam int unsigned RW    = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [5:0]    filt_in,
  output logic          busy,
  input  logic          row_valid,
  output logic          row_ready,
  input  logic [15:0]   row_data,
  output logic [15:0]   pe_in,
  output logic [5:0]    pe_filter,
  input  logic [11:0]   pe_out,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [11:0]   res_data,
  output logic [RW-1:0] res_row,
  output logic          done
);

  localparam int unsigned LW       = (PE_LAT > 0) ? $clog2(PE_LAT + 1) : 1;
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
  localparam logic [LW-1:0] LAT_LOAD = LW'(PE_LAT);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FEED = 3'd1,
    S_WAIT = 3'd2,
    S_EMIT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [RW-1:0] row_cnt_q;
  logic [LW-1:0] lat_cnt_q;
  logic          start_c;
  logic          acc_c;
  logic          cap_c;
  logic          hs_c;
  logic          last_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode and datapath enables
  always_comb begin
    state_d = state_q;
    start_c = 1'b0;
    acc_c   = 1'b0;
    cap_c   = 1'b0;
    hs_c    = 1'b0;
    last_c  = (row_cnt_q == LAST_ROW);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          start_c = 1'b1;
          state_d = S_FEED;
        end
      end
      S_FEED: begin
        if (row_valid && row_ready) begin
          acc_c   = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (lat_cnt_q == '0) begin
          cap_c   = 1'b1;
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (res_valid && res_ready) begin
          hs_c    = 1'b1;
          state_d = last_c ? S_DONE : S_FEED;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Filter, row, latency and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pe_filter <= '0;
      pe_in     <= '0;
      row_cnt_q <= '0;
      lat_cnt_q <= '0;
      res_data  <= '0;
      res_row   <= '0;
    end else begin
      if (start_c) begin
        pe_filter <= filt_in;
        row_cnt_q <= '0;
      end else if (hs_c && !last_c) begin
        row_cnt_q <= row_cnt_q + RW'(1);
      end
      if (acc_c) begin
        pe_in     <= row_data;
        lat_cnt_q <= LAT_LOAD;
      end else if ((state_q == S_WAIT) && (lat_cnt_q != '0)) begin
        lat_cnt_q <= lat_cnt_q - LW'(1);
      end
      if (cap_c) begin
        res_data <= pe_out;
        res_row  <= row_cnt_q;
      end
    end
  end

  // Status outputs track the state they will be in, so they switch with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      row_ready <= 1'b0;
      res_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      busy      <= (state_d != S_IDLE);
      row_ready <= (state_d == S_FEED);
      res_valid <= (state_d == S_EMIT);
      done      <= (state_d == S_DONE);
    end
  end

endmodule
